// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one pipelined (ZBT-style) SRAM between the camera
// write path and the DWT read path. One access per cycle, reads return in
// grant order with fixed latency, and a streak counter bounds how long the
// non-preferred side can be kept waiting.
module sram_port_arbiter #(
    parameter int ADDR_W    = 18,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 2,
    parameter int BURST_MAX = 8
) (
    input  logic              clk_100,
    input  logic              rst,
    input  logic              arb_en,
    input  logic              prio_dwt,
    input  logic              cam_wr_req,
    input  logic [ADDR_W-1:0] cam_wr_addr,
    input  logic [DATA_W-1:0] cam_wr_data,
    output logic              cam_wr_ack,
    input  logic              dwt_rd_req,
    input  logic [ADDR_W-1:0] dwt_rd_addr,
    output logic              dwt_rd_ack,
    output logic [DATA_W-1:0] dwt_rd_data,
    output logic              dwt_rd_valid,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_ce_n,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_wdata_oe,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam logic [7:0] BURST_MAX_C = 8'(BURST_MAX);

    logic              pref_req;
    logic              oth_req;
    logic              grant_pref;
    logic              grant_oth;
    logic              grant_cam;
    logic              grant_dwt;
    logic              grant;
    logic              prio_q;
    logic              prio_chg;
    logic              streak_at_max;
    logic [7:0]        streak_cnt;
    logic              rd_phase;

    // Operation pipeline: index 0 is the address cycle, index RD_LAT the data cycle.
    logic              vld_p   [0:RD_LAT];
    logic              wr_p    [0:RD_LAT];
    logic [DATA_W-1:0] wdata_p [0:RD_LAT];

    // Streak counter increment, saturating at BURST_MAX.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v >= BURST_MAX_C) ? v : v + 8'd1;
    endfunction

    assign prio_chg      = (prio_dwt != prio_q);
    assign streak_at_max = (streak_cnt == BURST_MAX_C);

    // Grant decision: preferred side wins ties until its streak hits BURST_MAX.
    always_comb begin
        pref_req   = prio_dwt ? dwt_rd_req : cam_wr_req;
        oth_req    = prio_dwt ? cam_wr_req : dwt_rd_req;
        grant_pref = 1'b0;
        grant_oth  = 1'b0;
        if (arb_en) begin
            if (pref_req && oth_req) begin
                if (streak_at_max) begin
                    grant_oth = 1'b1;
                end else begin
                    grant_pref = 1'b1;
                end
            end else if (pref_req) begin
                grant_pref = 1'b1;
            end else if (oth_req) begin
                grant_oth = 1'b1;
            end
        end
        grant_cam = prio_dwt ? grant_oth : grant_pref;
        grant_dwt = prio_dwt ? grant_pref : grant_oth;
        grant     = grant_cam | grant_dwt;
    end

    // Acks are combinational so the requester advances on the sampling edge.
    assign cam_wr_ack = rst & grant_cam;
    assign dwt_rd_ack = rst & grant_dwt;

    // Previous priority setting, only used to spot a change; tracks through reset.
    always_ff @(posedge clk_100) begin
        prio_q <= prio_dwt;
    end

    // Starvation bound: count preferred grants made while the other side waits.
    always_ff @(posedge clk_100 or negedge rst) begin
        if (!rst) begin
            streak_cnt <= 8'd0;
        end else if (prio_chg || grant_oth || !oth_req) begin
            streak_cnt <= 8'd0;
        end else if (grant_pref) begin
            streak_cnt <= sat_inc(streak_cnt);
        end
    end

    // Address cycle pins; the address holds between accesses.
    always_ff @(posedge clk_100 or negedge rst) begin
        if (!rst) begin
            sram_addr <= '0;
            sram_ce_n <= 1'b1;
            sram_we_n <= 1'b1;
        end else begin
            sram_ce_n <= ~grant;
            sram_we_n <= ~grant_cam;
            if (grant) begin
                sram_addr <= grant_cam ? cam_wr_addr : dwt_rd_addr;
            end
        end
    end

    // Shift register carrying each access from address cycle to data cycle.
    always_ff @(posedge clk_100 or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i <= RD_LAT; i++) begin
                vld_p[i]   <= 1'b0;
                wr_p[i]    <= 1'b0;
                wdata_p[i] <= '0;
            end
        end else begin
            vld_p[0]   <= grant;
            wr_p[0]    <= grant_cam;
            wdata_p[0] <= grant_cam ? cam_wr_data : '0;
            for (int i = 1; i <= RD_LAT; i++) begin
                vld_p[i]   <= vld_p[i-1];
                wr_p[i]    <= wr_p[i-1];
                wdata_p[i] <= wdata_p[i-1];
            end
        end
    end

    // Data cycle: write and read phases come from the same stage, so the
    // FPGA drive enable and the SRAM output enable can never overlap.
    assign rd_phase      = vld_p[RD_LAT] & ~wr_p[RD_LAT];
    assign sram_oe_n     = ~rd_phase;
    assign sram_wdata_oe = vld_p[RD_LAT] & wr_p[RD_LAT];
    assign sram_wdata    = wdata_p[RD_LAT];

    // Capture the bus at the end of the read data cycle and strobe it out.
    always_ff @(posedge clk_100 or negedge rst) begin
        if (!rst) begin
            dwt_rd_valid <= 1'b0;
            dwt_rd_data  <= '0;
        end else begin
            dwt_rd_valid <= rd_phase;
            if (rd_phase) begin
                dwt_rd_data <= sram_rdata;
            end
        end
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Single-port arbiter and sequencer for the external 32-bit pipelined (ZBT-style) SRAM. It shares the SRAM between two requesters: the camera pixel write path, which stores captured frames, and the DWT coefficient read path, which feeds jpeg2000_top. It grants at most one access per clk_100 cycle and drives the SRAM address, control and data-enable pins. It returns read data in order with fixed latency, and bounds starvation of the lower-priority requester.

## Interface
Parameters:
- ADDR_W, 18, SRAM word address width
- DATA_W, 32, SRAM data width
- RD_LAT, 2, SRAM cycles from address cycle to data-on-bus cycle (2..4)
- BURST_MAX, 8, maximum consecutive grants to the preferred side while the other side waits (1..255)

Ports:
- clk_100  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- arb_en  in  1  1 = new grants allowed; 0 = no new grants, in-flight accesses still complete
- prio_dwt  in  1  1 = DWT reads preferred; 0 = camera writes preferred
- cam_wr_req  in  1  camera write request, held until acknowledged
- cam_wr_addr  in  ADDR_W  write word address
- cam_wr_data  in  DATA_W  write data
- cam_wr_ack  out  1  write accepted this cycle (combinational)
- dwt_rd_req  in  1  DWT read request, held until acknowledged
- dwt_rd_addr  in  ADDR_W  read word address
- dwt_rd_ack  out  1  read accepted this cycle (combinational)
- dwt_rd_data  out  DATA_W  returned read data
- dwt_rd_valid  out  1  one-cycle strobe qualifying dwt_rd_data
- sram_addr  out  ADDR_W  SRAM address
- sram_ce_n  out  1  chip enable, active-low
- sram_we_n  out  1  write enable, active-low
- sram_oe_n  out  1  output enable, active-low
- sram_wdata  out  DATA_W  write data to the pad tristate
- sram_wdata_oe  out  1  1 = FPGA drives the data bus
- sram_rdata  in  DATA_W  data bus input

## Operation
- Requests follow a req/ack handshake. A requester holds req, addr and data stable until ack is high. Ack is asserted in the same cycle the request is sampled, and the requester advances on that edge.
- Grant rule, evaluated every cycle while arb_en=1 and rst=1:
  - One request active: grant it.
  - Both requests active: grant the preferred side (set by prio_dwt), unless streak_cnt == BURST_MAX. In that case grant the other side for one cycle and clear streak_cnt.
  - Neither active: no grant.
  - At most one ack is high per cycle.
- streak_cnt is an 8-bit counter:
  - It increments on each grant to the preferred side while the other side's req is high.
  - It clears when the other side is granted, when the other side's req is low, or when prio_dwt changes.
  - It saturates at BURST_MAX.
- Operation pipeline: a shift register of depth RD_LAT+1 carrying {valid, is_write, wdata}.
  - Stage 0 is loaded on grant.
  - Stage RD_LAT drives the data-phase signals.
- The data bus never has both sram_wdata_oe=1 and sram_oe_n=0 in the same cycle. Because address and data phases keep a fixed offset, no turnaround bubbles are inserted.
- When arb_en falls, acks stop immediately. Accesses already granted complete normally.
- Reset asserted mid-operation:
  - The pipeline is flushed and all outputs take their reset values asynchronously.
  - Pending reads are discarded; no dwt_rd_valid is emitted for them after release.

## Timing
Request accepted in cycle T (ack=1):
- T+1: sram_addr = request address, sram_ce_n=0, sram_we_n = 0 for a write or 1 for a read.
- T+1+RD_LAT:
  - Write: sram_wdata = write data, sram_wdata_oe=1.
  - Read: sram_oe_n=0 and sram_rdata is sampled at the end of the cycle.
- T+2+RD_LAT: for a read, dwt_rd_valid=1 for one cycle with the captured data.

General rules:
- Throughput is one access per cycle. Reads return in grant order.
- Cycle with no grant: sram_ce_n=1, sram_we_n=1, sram_addr holds its last value.
- Reset values:
  - sram_addr=0, sram_ce_n=1, sram_we_n=1, sram_oe_n=1
  - sram_wdata=0, sram_wdata_oe=0
  - dwt_rd_data=0, dwt_rd_valid=0
  - cam_wr_ack=0, dwt_rd_ack=0
  - streak_cnt=0, pipeline empty
- Acks are forced to 0 while rst=0.

## Test plan
All scenarios use RD_LAT=2 and BURST_MAX=8.
- Single write, addr 0x00010, data 0xA5A51234:
  - Ack in T.
  - T+1: addr 0x00010, we_n=0, ce_n=0.
  - T+3: wdata=0xA5A51234, wdata_oe=1.
- Single read, addr 0x3FFFF, SRAM model returns 0xDEADBEEF:
  - T+3: oe_n=0.
  - T+4: dwt_rd_valid=1, dwt_rd_data=0xDEADBEEF.
  - No other valid strobes.
- Both requesters continuous, prio_dwt=1:
  - Grant pattern repeats 8 DWT, 1 camera with no idle cycles.
  - With prio_dwt=0 the pattern becomes 8 camera, 1 DWT.
- Alternating read/write on addresses 0..15 against the SRAM model:
  - Every read returns the last-written value, in order.
  - wdata_oe=1 and oe_n=0 never occur in the same cycle.
- rst driven low with 2 reads in flight:
  - All outputs take reset values in the same cycle.
  - No dwt_rd_valid within 10 cycles after release.
- arb_en driven to 0 during a 4-read burst after 2 grants:
  - No further acks.
  - Exactly 2 dwt_rd_valid pulses, at T+4 and T+5.
